dds_relay_ctrl: RTL and testbench

Parametrised Avalon-MM output-port controller for the DDS output relays and attenuator switches. It replaces the single-bit output PIO with a WIDTH-bit port that has atomic set/clear access and a programmable settle time. An optional break-before-make sequencer drives the outputs. A busy flag and a settle-done interrupt let the Nios II firmware know when the analog path is stable.

---
 rtl/dds_relay_ctrl_if.sv | 18 +
 rtl/dds_relay_ctrl.sv | 115 +++++++++++
 tb/tb_dds_relay_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_relay_ctrl_if.sv
// Avalon-MM slave bus bundle for the DDS relay output controller.
interface dds_relay_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/dds_relay_ctrl.sv
// DDS relay / attenuator output port with atomic set/clear, programmable
// settle time, optional break-before-make sequencing and settle-done irq.
module dds_relay_ctrl #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      SETTLE_W       = 16,
  parameter int unsigned      DEFAULT_SETTLE = 50000,
  parameter int unsigned      BBM            = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  dds_relay_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, BREAK, MAKE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    req;
  logic [SETTLE_W-1:0] settle;
  logic [SETTLE_W-1:0] cnt;
  logic                irq_en;
  logic                pending;

  logic                wr;
  logic                pend_clr;
  logic                busy;
  logic                converge;
  state_t              ev_state;
  logic [WIDTH-1:0]    ev_out;
  logic [SETTLE_W-1:0] ev_cnt;
  logic                unused_wdata;

  assign wr           = bus.chipselect && !bus.write_n;
  assign pend_clr     = wr && (bus.address == 3'd1) && bus.writedata[1];
  assign busy         = (state != IDLE) || (req != out_port);
  assign converge     = (state != IDLE) && (cnt == '0) && (req == out_port);
  assign unused_wdata = ^bus.writedata;

  // Software-visible registers; REQ/SET/CLEAR accepted in any FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req    <= RESET_VALUE;
      settle <= SETTLE_W'(DEFAULT_SETTLE);
      irq_en <= 1'b0;
    end else if (wr) begin
      case (bus.address)
        3'd0:    req    <= bus.writedata[WIDTH-1:0];
        3'd2:    req    <= req | bus.writedata[WIDTH-1:0];
        3'd3:    req    <= req & ~bus.writedata[WIDTH-1:0];
        3'd4:    settle <= bus.writedata[SETTLE_W-1:0];
        3'd5:    irq_en <= bus.writedata[0];
        default: ;
      endcase
    end
  end

  // Evaluation step: decide the next phase from REQ versus the current drive
  always_comb begin
    ev_state = IDLE;
    ev_out   = out_port;
    ev_cnt   = cnt;
    if (req == out_port) begin
      ev_state = IDLE;
    end else if ((BBM != 0) && ((out_port & ~req) != '0)) begin
      ev_out   = out_port & req;
      ev_cnt   = settle;
      ev_state = BREAK;
    end else begin
      ev_out   = req;
      ev_cnt   = settle;
      ev_state = MAKE;
    end
  end

  // Sequencer: phase timing, relay drive, pending flag and registered irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      out_port <= RESET_VALUE;
      cnt      <= '0;
      pending  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= pending & irq_en;
      if ((state != IDLE) && (cnt != '0)) begin
        cnt <= cnt - SETTLE_W'(1);
      end else begin
        state    <= ev_state;
        out_port <= ev_out;
        cnt      <= ev_cnt;
      end
      // set has priority over a same-cycle clear
      if (converge)
        pending <= 1'b1;
      else if (pend_clr)
        pending <= 1'b0;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      3'd0:    bus.readdata = 32'(req);
      3'd1:    bus.readdata = {30'd0, pending, busy};
      3'd2:    bus.readdata = 32'(out_port);
      3'd4:    bus.readdata = 32'(settle);
      3'd5:    bus.readdata = {31'd0, irq_en};
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dds_relay_ctrl.sv
// Self-checking bench for dds_relay_ctrl: register table, hand-written
// sequencing corner cases, and randomized bus traffic against a model.
module tb_dds_relay_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_a, out_b;
  logic       irq_a, irq_b;
  int         passed;
  int         total;
  bit         chk_en;

  dds_relay_ctrl_if bus_a();
  dds_relay_ctrl_if bus_b();

  dds_relay_ctrl #(.WIDTH(8), .SETTLE_W(16), .DEFAULT_SETTLE(50000), .BBM(1), .RESET_VALUE(8'h00))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a), .out_port(out_a), .irq(irq_a));

  dds_relay_ctrl #(.WIDTH(8), .SETTLE_W(16), .DEFAULT_SETTLE(50000), .BBM(0), .RESET_VALUE(8'h00))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b), .out_port(out_b), .irq(irq_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model (instance A, BBM=1) ----------------
  // m_left: cycles remaining before the next evaluation, -1 when at rest.
  logic [7:0]  m_req, m_out;
  logic [15:0] m_settle;
  bit          m_irqen, m_pend, m_irq;
  int          m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_req = 8'h00; m_out = 8'h00; m_settle = 16'd50000;
      m_irqen = 0; m_pend = 0; m_irq = 0; m_left = -1;
    end else begin
      bit          wr, conv;
      logic [31:0] wd;
      logic [2:0]  a;
      wr   = bus_a.chipselect && !bus_a.write_n;
      wd   = bus_a.writedata;
      a    = bus_a.address;
      conv = 0;
      m_irq = m_pend && m_irqen;
      if (m_left > 0) m_left--;
      else if (m_req == m_out) begin
        conv   = (m_left == 0);
        m_left = -1;
      end else begin
        if ((m_out & ~m_req) != 0) m_out = m_out & m_req;
        else m_out = m_req;
        m_left = int'(m_settle);
      end
      if (conv) m_pend = 1;
      else if (wr && a == 3'd1 && wd[1]) m_pend = 0;
      if (wr) begin
        case (a)
          3'd0: m_req = wd[7:0];
          3'd2: m_req = m_req | wd[7:0];
          3'd3: m_req = m_req & ~wd[7:0];
          3'd4: m_settle = wd[15:0];
          3'd5: m_irqen = wd[0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [2:0] a);
    bit busy;
    busy = (m_left >= 0) || (m_req != m_out);
    case (a)
      3'd0: return {24'd0, m_req};
      3'd1: return {30'd0, m_pend, busy};
      3'd2: return {24'd0, m_out};
      3'd4: return {16'd0, m_settle};
      3'd5: return {31'd0, m_irqen};
      default: return 32'd0;
    endcase
  endfunction

  // continuous comparison against the model, away from the clock edge
  initial forever begin
    @(posedge clk);
    #3;
    if (chk_en && reset_n) begin
      check("mdl_out", {24'd0, out_a}, {24'd0, m_out});
      check("mdl_irq", {31'd0, irq_a}, {31'd0, m_irq});
      check("mdl_rd", bus_a.readdata, m_read(bus_a.address));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
    bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
    bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic wait_idle_a(input int maxc);
    bus_a.address = 3'd1;
    #1;
    for (int i = 0; i < maxc; i++) begin
      if (bus_a.readdata[0] == 1'b0) return;
      @(negedge clk); #1;
    end
    check("idle_a_timeout", {31'd0, bus_a.readdata[0]}, 32'd0);
  endtask

  task automatic wait_idle_b(input int maxc);
    bus_b.address = 3'd1;
    #1;
    for (int i = 0; i < maxc; i++) begin
      if (bus_b.readdata[0] == 1'b0) return;
      @(negedge clk); #1;
    end
    check("idle_b_timeout", {31'd0, bus_b.readdata[0]}, 32'd0);
  endtask

  // ---------------- register access table ----------------
  typedef struct {
    logic [2:0]  waddr;
    bit          we;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0] eo;
    logic [1:0] es;

    passed = 0; total = 0; chk_en = 0;
    reset_n = 1'b0;
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;

    vecs[0]  = '{3'd0, 1'b0, 32'h0,        3'd0, 32'd0};
    vecs[1]  = '{3'd0, 1'b0, 32'h0,        3'd1, 32'd0};
    vecs[2]  = '{3'd0, 1'b0, 32'h0,        3'd4, 32'd50000};
    vecs[3]  = '{3'd0, 1'b0, 32'h0,        3'd5, 32'd0};
    vecs[4]  = '{3'd0, 1'b0, 32'h0,        3'd2, 32'd0};
    vecs[5]  = '{3'd0, 1'b0, 32'h0,        3'd3, 32'd0};
    vecs[6]  = '{3'd4, 1'b1, 32'hFFFF0003, 3'd4, 32'd3};
    vecs[7]  = '{3'd5, 1'b1, 32'hFFFFFFFE, 3'd5, 32'd0};
    vecs[8]  = '{3'd5, 1'b1, 32'h00000003, 3'd5, 32'd1};
    vecs[9]  = '{3'd6, 1'b1, 32'h000000FF, 3'd6, 32'd0};
    vecs[10] = '{3'd7, 1'b1, 32'h000000FF, 3'd7, 32'd0};
    vecs[11] = '{3'd1, 1'b1, 32'h00000002, 3'd0, 32'd0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_out_a", {24'd0, out_a}, 32'd0);
    check("rst_irq_a", {31'd0, irq_a}, 32'd0);
    check("rst_out_b", {24'd0, out_b}, 32'd0);
    chk_en = 1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) wr_a(vecs[i].waddr, vecs[i].wdata);
      bus_a.address = vecs[i].raddr;
      #1;
      check($sformatf("tbl%0d", i), bus_a.readdata, vecs[i].exp);
    end

    // single MAKE phase, SETTLE=3, irq enabled
    wr_a(3'd0, 32'h05);
    bus_a.address = 3'd1;
    #1;
    check("s1_out_k0", {24'd0, out_a}, 32'h00);
    check("s1_st_k0", bus_a.readdata, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      es = {1'(k >= 5), 1'(k <= 4)};
      check($sformatf("s1_out_k%0d", k), {24'd0, out_a}, 32'h05);
      check($sformatf("s1_st_k%0d", k), bus_a.readdata, {30'd0, es});
      check($sformatf("s1_irq_k%0d", k), {31'd0, irq_a}, {31'd0, 1'(k >= 6)});
    end
    wr_a(3'd1, 32'h2);
    #1;
    check("s1_clr_st", bus_a.readdata, 32'h0);
    @(negedge clk); #1;
    check("s1_clr_irq", {31'd0, irq_a}, 32'd0);

    // break-before-make 0x0F -> 0xF0 with SETTLE=2
    wr_a(3'd4, 32'd2);
    wr_a(3'd0, 32'h0F);
    wait_idle_a(20);
    wr_a(3'd1, 32'h2);
    wr_a(3'd0, 32'hF0);
    bus_a.address = 3'd1;
    #1;
    check("s2_out_k0", {24'd0, out_a}, 32'h0F);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      eo = (k <= 3) ? 8'h00 : 8'hF0;
      es = {1'(k >= 7), 1'(k <= 6)};
      check($sformatf("s2_out_k%0d", k), {24'd0, out_a}, {24'd0, eo});
      check($sformatf("s2_st_k%0d", k), bus_a.readdata, {30'd0, es});
      check("s2_overlap", {31'd0, 1'((out_a & 8'h0F) != 0 && (out_a & 8'hF0) != 0)}, 32'd0);
    end

    // BBM=0 instance: direct single step 0x0F -> 0xF0
    wr_b(3'd4, 32'd2);
    wr_b(3'd0, 32'h0F);
    wait_idle_b(20);
    wr_b(3'd1, 32'h2);
    wr_b(3'd0, 32'hF0);
    bus_b.address = 3'd1;
    #1;
    check("s3_out_k0", {24'd0, out_b}, 32'h0F);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      es = {1'(k >= 4), 1'(k <= 3)};
      check($sformatf("s3_out_k%0d", k), {24'd0, out_b}, 32'hF0);
      check($sformatf("s3_st_k%0d", k), bus_b.readdata, {30'd0, es});
    end

    // SET/CLEAR landing inside a running MAKE phase, SETTLE=3
    wr_a(3'd4, 32'd3);
    wr_a(3'd0, 32'h01);
    wait_idle_a(40);
    wr_a(3'd1, 32'h2);
    wr_a(3'd2, 32'h02);
    wr_a(3'd2, 32'h80);
    wr_a(3'd3, 32'h01);
    bus_a.address = 3'd1;
    #1;
    for (int k = 2; k <= 14; k++) begin
      if (k > 2) begin @(negedge clk); #1; end
      eo = (k < 5) ? 8'h03 : (k < 9) ? 8'h02 : 8'h82;
      es = {1'(k >= 13), 1'(k <= 12)};
      check($sformatf("s4_out_k%0d", k), {24'd0, out_a}, {24'd0, eo});
      check($sformatf("s4_st_k%0d", k), bus_a.readdata, {30'd0, es});
    end

    // reset asserted in the middle of a BREAK phase
    wr_a(3'd0, 32'h0F);
    @(negedge clk); #1;
    check("s5_break_out", {24'd0, out_a}, 32'h02);
    reset_n = 1'b0;
    #1;
    check("s5_rst_out", {24'd0, out_a}, 32'h00);
    check("s5_rst_irq", {31'd0, irq_a}, 32'd0);
    bus_a.address = 3'd1; #1;
    check("s5_rst_st", bus_a.readdata, 32'h0);
    bus_a.address = 3'd4; #1;
    check("s5_rst_settle", bus_a.readdata, 32'd50000);
    bus_a.address = 3'd0; #1;
    check("s5_rst_req", bus_a.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_a.address = 3'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("s5_post_out", {24'd0, out_a}, 32'h00);
      check("s5_post_st", bus_a.readdata, 32'h0);
    end

    // pending set and STATUS clear in the same cycle: set wins
    wr_a(3'd4, 32'd0);
    wr_a(3'd0, 32'h01);
    @(negedge clk);
    wr_a(3'd1, 32'h2);
    bus_a.address = 3'd1; #1;
    check("s6_setwins", bus_a.readdata, 32'h2);
    wr_a(3'd1, 32'h2);
    #1;
    check("s6_cleared", bus_a.readdata, 32'h0);

    // randomized bus traffic, checked continuously against the model
    wr_a(3'd4, 32'd1);
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk); #1;
      bus_a.address    = 3'($urandom_range(0, 7));
      bus_a.chipselect = ($urandom_range(0, 3) != 0);
      bus_a.write_n    = ($urandom_range(0, 2) != 0);
      bus_a.writedata  = (bus_a.address == 3'd4) ? 32'($urandom_range(0, 3)) : $urandom;
    end
    @(negedge clk); #1;
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
